// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, mispredict redirect/flush, memory hold.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int PC_W         = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            memory_stall,
    input  logic [4:0]      Rs1_1,
    input  logic [4:0]      Rs2_1,
    input  logic            uses_rs2_1,
    input  logic [1:0]      Mem_2,
    input  logic [4:0]      Rd_2,
    input  logic            is_branchInst_3,
    input  logic            taken_3,
    input  logic            prev_taken_3,
    input  logic [PC_W-1:0] target_3,
    output logic            stall_pc,
    output logic            stall_1,
    output logic            stall_2,
    output logic            bubble_2,
    output logic            flush_1,
    output logic            flush_2,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
`ifdef PERF_CNT_EN
    output logic [PERF_W-1:0] cnt_ldstall,
    output logic [PERF_W-1:0] cnt_flush,
    output logic [PERF_W-1:0] cnt_memstall,
`endif
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic load_use;
    logic mispredict;
    logic unused_mem_write;

    logic stall_pc_c, stall_1_c, stall_2_c, bubble_2_c;
    logic flush_1_c, flush_2_c, redirect_valid_c;

    assign unused_mem_write = Mem_2[0];

    assign load_use   = Mem_2[1] && (Rd_2 != 5'd0) &&
                        ((Rd_2 == Rs1_1) || (uses_rs2_1 && (Rd_2 == Rs2_1)));
    assign mispredict = is_branchInst_3 && (taken_3 != prev_taken_3);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stall_pc_c       = 1'b0;
        stall_1_c        = 1'b0;
        stall_2_c        = 1'b0;
        bubble_2_c       = 1'b0;
        flush_1_c        = 1'b0;
        flush_2_c        = 1'b0;
        redirect_valid_c = 1'b0;
        if (memory_stall) begin
            // Whole pipeline holds; any pending redirect waits for the stall to drop.
            stall_pc_c = 1'b1;
            stall_1_c  = 1'b1;
            stall_2_c  = 1'b1;
        end else begin
            case (state_q)
                RUN, LD_STALL: begin
                    if (mispredict) begin
                        redirect_valid_c = 1'b1;
                        flush_1_c        = 1'b1;
                        flush_2_c        = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (load_use && (state_q == RUN)) begin
                        stall_pc_c = 1'b1;
                        stall_1_c  = 1'b1;
                        bubble_2_c = 1'b1;
                        state_d    = LD_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    // Redirect cycle already flushed once, so FLUSH lasts FLUSH_CYCLES-1 cycles.
                    flush_1_c = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_pc       = rst_n & stall_pc_c;
    assign stall_1        = rst_n & stall_1_c;
    assign stall_2        = rst_n & stall_2_c;
    assign bubble_2       = rst_n & bubble_2_c;
    assign flush_1        = rst_n & flush_1_c;
    assign flush_2        = rst_n & flush_2_c;
    assign redirect_valid = rst_n & redirect_valid_c;
    assign redirect_pc    = rst_n ? target_3 : '0;
    assign state_o        = state_q;

`ifdef PERF_CNT_EN
    logic [PERF_W-1:0] cnt_ldstall_q, cnt_ldstall_d;
    logic [PERF_W-1:0] cnt_flush_q, cnt_flush_d;
    logic [PERF_W-1:0] cnt_memstall_q, cnt_memstall_d;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != {PERF_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        cnt_ldstall_d  = sat_inc(cnt_ldstall_q, bubble_2_c);
        cnt_flush_d    = sat_inc(cnt_flush_q, redirect_valid_c);
        cnt_memstall_d = sat_inc(cnt_memstall_q, memory_stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ldstall_q  <= '0;
            cnt_flush_q    <= '0;
            cnt_memstall_q <= '0;
        end else begin
            cnt_ldstall_q  <= cnt_ldstall_d;
            cnt_flush_q    <= cnt_flush_d;
            cnt_memstall_q <= cnt_memstall_d;
        end
    end

    assign cnt_ldstall  = cnt_ldstall_q;
    assign cnt_flush    = cnt_flush_q;
    assign cnt_memstall = cnt_memstall_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3); PERF_CNT_EN adds counter checks.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       memory_stall;
    logic [4:0] Rs1_1, Rs2_1, Rd_2;
    logic       uses_rs2_1;
    logic [1:0] Mem_2;
    logic       is_branchInst_3, taken_3, prev_taken_3;
    logic [7:0] target_3;
    logic       stall_pc, stall_1, stall_2, bubble_2, flush_1, flush_2, redirect_valid;
    logic [7:0] redirect_pc;
    logic [1:0] state_o;
`ifdef PERF_CNT_EN
    logic [15:0] cnt_ldstall, cnt_flush, cnt_memstall;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.PC_W(8), .FLUSH_CYCLES(3), .PERF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall),
        .Rs1_1(Rs1_1), .Rs2_1(Rs2_1), .uses_rs2_1(uses_rs2_1),
        .Mem_2(Mem_2), .Rd_2(Rd_2),
        .is_branchInst_3(is_branchInst_3), .taken_3(taken_3),
        .prev_taken_3(prev_taken_3), .target_3(target_3),
        .stall_pc(stall_pc), .stall_1(stall_1), .stall_2(stall_2),
        .bubble_2(bubble_2), .flush_1(flush_1), .flush_2(flush_2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef PERF_CNT_EN
        .cnt_ldstall(cnt_ldstall), .cnt_flush(cnt_flush), .cnt_memstall(cnt_memstall),
`endif
        .state_o(state_o)
    );

    // flags: {stall_pc, stall_1, stall_2, bubble_2, flush_1, flush_2, redirect_valid}
    function automatic logic [16:0] ev(input logic [6:0] f, input logic [7:0] pc, input logic [1:0] st);
        return {f, pc, st};
    endfunction

    task automatic set_in(input logic ms, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u2, input logic [1:0] mem, input logic [4:0] rd,
                          input logic br, input logic tk, input logic ptk, input logic [7:0] tgt);
        memory_stall = ms; Rs1_1 = rs1; Rs2_1 = rs2; uses_rs2_1 = u2; Mem_2 = mem; Rd_2 = rd;
        is_branchInst_3 = br; taken_3 = tk; prev_taken_3 = ptk; target_3 = tgt;
    endtask

    task automatic check(input string tag);
        logic [16:0] exp, obs;
        exp = sb.pop_front();
        obs = {stall_pc, stall_1, stall_2, bubble_2, flush_1, flush_2, redirect_valid,
               redirect_pc, state_o};
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [16:0] e);
        sb.push_back(e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

`ifdef PERF_CNT_EN
    task automatic check_perf(input string tag, input logic [15:0] el, input logic [15:0] ef,
                              input logic [15:0] em);
        n_vec++;
        assert ({cnt_ldstall, cnt_flush, cnt_memstall} === {el, ef, em}) else begin
            n_fail++;
            $error("FAIL %s observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
                   cnt_ldstall, cnt_flush, cnt_memstall, el, ef, em);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 8'h40);
        step("reset_gated", ev(7'b0000000, 8'h00, 2'd0));
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
        step("idle", ev(7'b0000000, 8'h00, 2'd0));

        // lw x5 followed by add x6,x5,x1
        set_in(0, 5, 1, 1, 2'b10, 5, 0, 0, 0, 8'h00);
        step("ld_use_rs1", ev(7'b1101000, 8'h00, 2'd0));
        step("ld_stall_masked", ev(7'b0000000, 8'h00, 2'd1));
        set_in(0, 5, 1, 1, 2'b00, 5, 0, 0, 0, 8'h00);
        step("back_to_run", ev(7'b0000000, 8'h00, 2'd0));
        set_in(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 8'h00);
        step("rd_x0_no_stall", ev(7'b0000000, 8'h00, 2'd0));
        set_in(0, 3, 7, 0, 2'b10, 7, 0, 0, 0, 8'h00);
        step("rs2_unused_no_stall", ev(7'b0000000, 8'h00, 2'd0));
        set_in(0, 3, 7, 1, 2'b10, 7, 0, 0, 0, 8'h00);
        step("ld_use_rs2", ev(7'b1101000, 8'h00, 2'd0));

        // mispredict taken while in LD_STALL, then two FLUSH cycles ignoring hazards
        set_in(0, 3, 7, 1, 2'b10, 7, 1, 1, 0, 8'h40);
        step("mispred_in_ldstall", ev(7'b0000111, 8'h40, 2'd1));
        step("flush_cyc1", ev(7'b0000100, 8'h40, 2'd2));
        step("flush_cyc2", ev(7'b0000100, 8'h40, 2'd2));
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
        step("flush_done", ev(7'b0000000, 8'h00, 2'd0));

        // mispredict held off by 4 cycles of memory stall
        set_in(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 8'h80);
        for (int i = 0; i < 4; i++) step("memstall_hold", ev(7'b1110000, 8'h80, 2'd0));
        memory_stall = 1'b0;
        step("redirect_after_memstall", ev(7'b0000111, 8'h80, 2'd0));
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
        step("flush_a", ev(7'b0000100, 8'h00, 2'd2));
        memory_stall = 1'b1;
        step("memstall_in_flush", ev(7'b1110000, 8'h00, 2'd2));
        memory_stall = 1'b0;
        step("flush_b", ev(7'b0000100, 8'h00, 2'd2));

        // load-use and mispredict together: redirect wins, no bubble
        set_in(0, 9, 0, 0, 2'b10, 9, 1, 1, 0, 8'h24);
        step("mispred_over_lduse", ev(7'b0000111, 8'h24, 2'd0));
`ifdef PERF_CNT_EN
        check_perf("perf_counts", 16'd2, 16'd3, 16'd5);
`endif
        step("flush_before_reset", ev(7'b0000100, 8'h24, 2'd2));

        // asynchronous reset while in FLUSH
        rst_n = 1'b0;
        sb.push_back(ev(7'b0000000, 8'h00, 2'd0));
        #2;
        check("async_reset_in_flush");
`ifdef PERF_CNT_EN
        check_perf("perf_reset", 16'd0, 16'd0, 16'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
        step("after_reset", ev(7'b0000000, 8'h00, 2'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
